// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller signal bundle between pipeline datapath and control
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr_ifid;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic             ex_redirect;
    logic             imem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       state;

    // Datapath side: presents pipeline status, consumes the control strobes.
    modport master (
        output instr_ifid, idex_memread, idex_rt, ex_redirect, imem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  instr_ifid, idex_memread, idex_rt, ex_redirect, imem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - IF/ID and PC sequencing for load-use, imem wait and EX redirect hazards
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.slave   hz
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_IWAIT = 2'd2
    } state_t;

    localparam logic [1:0] FCNT_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       load_use;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;

    // Hazard decode on the instruction sitting in ID.
    always_comb begin
        opcode   = hz.instr_ifid[31:26];
        rs       = hz.instr_ifid[25:21];
        rt       = hz.instr_ifid[20:16];
        uses_rt  = (opcode == 6'h00) || (opcode == 6'h04) ||
                   (opcode == 6'h05) || (opcode == 6'h2B);
        load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                   ((hz.idex_rt == rs) || (uses_rt && (hz.idex_rt == rt)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (hz.ex_redirect) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                fcnt_d  = FCNT_RELOAD;
            end else begin
                state_d = ST_RUN;
                fcnt_d  = 2'd0;
            end
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (fcnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        fcnt_d  = 2'd0;
                    end else begin
                        fcnt_d  = fcnt_q - 2'd1;
                    end
                end
                // A load-use hold also ends here: the load has left EX next cycle.
                default: state_d = hz.imem_ready ? ST_RUN : ST_IWAIT;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hz.ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            // ID already holds a NOP here, so load-use cannot apply.
            pc_write    = hz.imem_ready;
            ifid_flush  = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (!hz.imem_ready) begin
            pc_write    = 1'b0;
            ifid_flush  = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (hz.ex_redirect && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
    assign hz.state       = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit that sequences the IF/ID pipeline register and the PC of the 5-stage MIPS pipeline. It detects load-use hazards, instruction-memory wait states and control-flow redirects resolved in EX. It drives the PC write enable, the IF/ID write/flush controls and the ID/EX bubble select. It also keeps saturating stall and flush event counters for performance analysis.

## Interface
- FLUSH_CYCLES, 1: cycles ifid_flush stays asserted per redirect, range 1–3.
- CNT_W, 16: width of the performance counters.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- instr_ifid  in  32  instruction held in IF/ID. Fields: opcode [31:26], rs [25:21], rt [20:16].
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  5  destination register of the load in EX.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- pc_write  out  1  PC loads its next value.
- ifid_write  out  1  IF/ID captures instr/pc_4.
- ifid_flush  out  1  IF/ID loads 32'h0 (NOP) instead of instr.
- idex_bubble  out  1  ID/EX control fields forced to zero.
- stall_cnt  out  CNT_W  cycles with pc_write=0 since reset; saturates.
- flush_cnt  out  CNT_W  redirect events since reset; saturates.
- state  out  2  debug: 0=RUN, 1=FLUSH, 2=IWAIT.

## Operation
- Load-use hazard (LU) = idex_memread & (idex_rt != 0) & ((idex_rt == rs) | (uses_rt & idex_rt == rt)).
  - uses_rt is true for opcode 0x00, 0x04, 0x05 and 0x2B.
- Priority per cycle: redirect > LU > !imem_ready > normal.
- Normal (RUN, no event): pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Redirect:
  - pc_write=1 so the PC takes the target.
  - ifid_flush=1, ifid_write=1, idex_bubble=1.
  - flush_cnt increments.
  - If FLUSH_CYCLES>1, go to FLUSH with fcnt = FLUSH_CYCLES-1.
- LU, no redirect:
  - pc_write=0, ifid_write=0 (hold), idex_bubble=1, ifid_flush=0.
  - Lasts exactly one cycle, because the load leaves EX.
- !imem_ready, no redirect, no LU:
  - pc_write=0, ifid_write=1, ifid_flush=1 (a NOP enters ID), idex_bubble=0.
  - Go to IWAIT.
- LU & !imem_ready: LU outputs apply; hold wins over flush. Go to IWAIT.
- FLUSH state:
  - ifid_flush=1, pc_write=imem_ready, idex_bubble=0.
  - fcnt decrements; return to RUN when fcnt reaches 0.
  - A new redirect in FLUSH reloads fcnt and increments flush_cnt.
- IWAIT state:
  - Outputs follow the !imem_ready rule while imem_ready=0.
  - On imem_ready=1, apply normal outputs in that cycle and return to RUN.
  - A redirect in IWAIT follows the redirect rule and exits to RUN or FLUSH.
- stall_cnt increments every cycle pc_write=0 (reset cycles excluded); holds at all-ones.
- flush_cnt holds at all-ones.

## Timing
- Hazard and redirect decode is combinational from the inputs plus registered state, so outputs are valid in the same cycle.
- State, fcnt and counters update on posedge clk.
- While rst_n=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
- After a posedge with rst_n=0: state=RUN, fcnt=0, stall_cnt=0, flush_cnt=0.
- Reset mid-FLUSH or mid-IWAIT aborts to RUN; there is no residual flush.
- Load-use penalty is 1 cycle. Redirect penalty is FLUSH_CYCLES cycles. Memory wait penalty equals the number of imem_ready=0 cycles.
- No combinational path from outputs back to inputs inside the block.

## Test plan
- Reset, then instr=add $3,$1,$2 with idex_memread=0: all outputs at normal values; stall_cnt stays 0.
- idex_memread=1, idex_rt=1, instr_ifid rs=1: one cycle with pc_write=0, ifid_write=0, idex_bubble=1, then normal; stall_cnt=1. Repeat with idex_rt=0: no stall.
- Load to rt=5, instr_ifid = lw $6,0($5) (uses_rt=0, rt≠5, rs=5): stall. With instr_ifid = addi $5,$0,1 (rt=5, uses_rt=0): no stall.
- ex_redirect pulse with FLUSH_CYCLES=2: ifid_flush=1 for 2 cycles, idex_bubble only in the first, flush_cnt=1. A second redirect in cycle 2 extends the flush by 2 more cycles; flush_cnt=2.
- imem_ready=0 for 3 cycles: state=IWAIT, pc_write=0 and ifid_flush=1 for 3 cycles, then RUN; stall_cnt=3. A redirect in the middle wins, with pc_write=1.
- Same cycle LU + ex_redirect: redirect outputs, no hold. Force stall_cnt to 0xFFFF via a long wait: it stays at 0xFFFF.
